// File: rtl/count_down_timer.sv
// Countdown timer with an MM:SS.cc seven-segment display. Two active-low buttons
// load a preset and toggle run/pause; fDone rises when the count reaches 00:00.00.
module count_down_timer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_DIV = CLK_HZ / 100
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        fStart,
  input  logic        fLoad,
  input  logic [23:0] Preset,
  output logic [6:0]  Sec0,
  output logic [6:0]  Sec1,
  output logic [6:0]  Sec2,
  output logic [6:0]  Sec3,
  output logic [6:0]  Sec4,
  output logic [6:0]  Sec5,
  output logic        fDone
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t            state, state_next;
  logic [5:0][3:0]   digits, digits_next, digits_dec, digits_preset;
  logic [DIV_W-1:0]  div, div_next;
  logic              done_next;

  logic start_s1, start_s2, start_prev;
  logic load_s1, load_s2, load_prev;
  logic start_ev, load_ev;

  function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Digit 3 (sec tens) and digit 5 (min tens) roll over to 5; all others to 9.
  function automatic logic [5:0][3:0] bcd_dec(input logic [5:0][3:0] d);
    logic [5:0][3:0] r;
    logic            borrow;
    logic [3:0]      top;
    r      = d;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      top = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (d[i] == 4'd0) begin
          r[i] = top;
        end else begin
          r[i]   = d[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      start_s1   <= 1'b1;
      start_s2   <= 1'b1;
      start_prev <= 1'b1;
      load_s1    <= 1'b1;
      load_s2    <= 1'b1;
      load_prev  <= 1'b1;
    end else begin
      start_s1   <= fStart;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      load_s1    <= fLoad;
      load_s2    <= load_s1;
      load_prev  <= load_s2;
    end
  end

  assign start_ev = start_prev & ~start_s2;
  assign load_ev  = load_prev & ~load_s2;

  assign digits_preset[5] = sat(Preset[23:20], 4'd5);
  assign digits_preset[4] = sat(Preset[19:16], 4'd9);
  assign digits_preset[3] = sat(Preset[15:12], 4'd5);
  assign digits_preset[2] = sat(Preset[11:8],  4'd9);
  assign digits_preset[1] = sat(Preset[7:4],   4'd9);
  assign digits_preset[0] = sat(Preset[3:0],   4'd9);

  assign digits_dec = bcd_dec(digits);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state  <= IDLE;
      digits <= '0;
      div    <= '0;
      fDone  <= 1'b0;
    end else begin
      state  <= state_next;
      digits <= digits_next;
      div    <= div_next;
      fDone  <= done_next;
    end
  end

  // A load outranks a simultaneous start; while running, loads are ignored.
  always_comb begin
    state_next  = state;
    digits_next = digits;
    div_next    = div;
    done_next   = fDone;
    if (load_ev && state != RUN) begin
      digits_next = digits_preset;
      div_next    = '0;
      done_next   = 1'b0;
      state_next  = IDLE;
    end else if (start_ev) begin
      case (state)
        IDLE: begin
          if (digits != '0) begin
            state_next = RUN;
            div_next   = '0;
          end
        end
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = state;
      endcase
    end else if (state == RUN) begin
      if (div == DIV_MAX) begin
        div_next    = '0;
        digits_next = digits_dec;
        if (digits_dec == '0) begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end else begin
        div_next = div + 1'b1;
      end
    end
  end

  assign Sec0 = seg7(digits[0]);
  assign Sec1 = seg7(digits[1]);
  assign Sec2 = seg7(digits[2]);
  assign Sec3 = seg7(digits[3]);
  assign Sec4 = seg7(digits[4]);
  assign Sec5 = seg7(digits[5]);

endmodule

// File: tb/tb_count_down_timer.sv
// Bench for count_down_timer: a centisecond-integer reference model checked every
// cycle, plus directed scenarios with hand-computed display values.
module tb_count_down_timer;

  localparam int TICK = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        fStart;
  logic        fLoad;
  logic [23:0] Preset;
  logic [6:0]  Sec0, Sec1, Sec2, Sec3, Sec4, Sec5;
  logic        fDone;

  int checks = 0;
  int errors = 0;

  // Reference model: the count is a plain number of centiseconds.
  int m_cs, m_div, m_state;
  bit m_done, m_valid = 1'b0;
  bit hist_start[3], hist_load[3];
  bit ev_start, ev_load;

  count_down_timer #(.TICK_DIV(TICK)) dut (
    .Clk(Clk), .Rst(Rst), .fStart(fStart), .fLoad(fLoad), .Preset(Preset),
    .Sec0(Sec0), .Sec1(Sec1), .Sec2(Sec2), .Sec3(Sec3), .Sec4(Sec4), .Sec5(Sec5),
    .fDone(fDone)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] cs_segs(input int cs);
    int mins, secs, cen;
    mins = cs / 6000;
    secs = (cs / 100) % 60;
    cen  = cs % 100;
    return {seg7(mins / 10), seg7(mins % 10), seg7(secs / 10), seg7(secs % 10),
            seg7(cen / 10), seg7(cen % 10)};
  endfunction

  function automatic int bcd_cs(input logic [23:0] b);
    return (int'(b[23:20]) * 10 + int'(b[19:16])) * 6000 +
           (int'(b[15:12]) * 10 + int'(b[11:8])) * 100 +
           int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int sat_cs(input logic [23:0] p);
    int mt, mo, st, so, ct, co;
    mt = (p[23:20] > 5) ? 5 : int'(p[23:20]);
    mo = (p[19:16] > 9) ? 9 : int'(p[19:16]);
    st = (p[15:12] > 5) ? 5 : int'(p[15:12]);
    so = (p[11:8]  > 9) ? 9 : int'(p[11:8]);
    ct = (p[7:4]   > 9) ? 9 : int'(p[7:4]);
    co = (p[3:0]   > 9) ? 9 : int'(p[3:0]);
    return (mt * 10 + mo) * 6000 + (st * 10 + so) * 100 + ct * 10 + co;
  endfunction

  // A button acts on the edge whose sample three edges back was high and two edges back low.
  always @(posedge Clk) begin
    if (!Rst) begin
      m_cs = 0; m_div = 0; m_state = M_IDLE; m_done = 1'b0; m_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        hist_start[i] = 1'b1;
        hist_load[i]  = 1'b1;
      end
    end else begin
      ev_start = hist_start[2] && !hist_start[1];
      ev_load  = hist_load[2] && !hist_load[1];
      if (ev_load && m_state != M_RUN) begin
        m_cs = sat_cs(Preset); m_div = 0; m_done = 1'b0; m_state = M_IDLE;
      end else if (ev_start) begin
        if (m_state == M_IDLE && m_cs != 0) begin
          m_state = M_RUN; m_div = 0;
        end else if (m_state == M_RUN) begin
          m_state = M_PAUSE;
        end else if (m_state == M_PAUSE) begin
          m_state = M_RUN;
        end
      end else if (m_state == M_RUN) begin
        m_div++;
        if (m_div == TICK) begin
          m_div = 0;
          m_cs--;
          if (m_cs == 0) begin
            m_state = M_DONE; m_done = 1'b1;
          end
        end
      end
      hist_start[2] = hist_start[1]; hist_start[1] = hist_start[0]; hist_start[0] = fStart;
      hist_load[2]  = hist_load[1];  hist_load[1]  = hist_load[0];  hist_load[0]  = fLoad;
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      checks++;
      if ({Sec5, Sec4, Sec3, Sec2, Sec1, Sec0} !== cs_segs(m_cs) || fDone !== m_done) begin
        errors++;
        $display("[TB] FAIL cycle_compare t=%0t: got segs=%h done=%b, want segs=%h done=%b",
                 $time, {Sec5, Sec4, Sec3, Sec2, Sec1, Sec0}, fDone, cs_segs(m_cs), m_done);
      end
    end
  end

  task automatic apply_stimulus(input bit start, input bit load, input int hold);
    fStart = ~start;
    fLoad  = ~load;
    repeat (hold) @(posedge Clk);
    #2;
    fStart = 1'b1;
    fLoad  = 1'b1;
  endtask

  task automatic wait_clocks(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic check_output(input string name, input logic [23:0] bcd, input bit done);
    logic [41:0] want;
    want = {seg7(bcd[23:20]), seg7(bcd[19:16]), seg7(bcd[15:12]), seg7(bcd[11:8]),
            seg7(bcd[7:4]), seg7(bcd[3:0])};
    checks++;
    if ({Sec5, Sec4, Sec3, Sec2, Sec1, Sec0} !== want) begin
      errors++;
      $display("[TB] FAIL %s segs: got %h, want %h", name, {Sec5, Sec4, Sec3, Sec2, Sec1, Sec0}, want);
    end
    checks++;
    if (fDone !== done) begin
      errors++;
      $display("[TB] FAIL %s fDone: got %b, want %b", name, fDone, done);
    end
    checks++;
    if (m_cs != bcd_cs(bcd)) begin
      errors++;
      $display("[TB] FAIL %s model_count: got %0d, want %0d", name, m_cs, bcd_cs(bcd));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rst = 1'b0; fStart = 1'b1; fLoad = 1'b1; Preset = 24'h0;
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b1;
    check_output("reset", 24'h000000, 1'b0);

    // Count across a seconds borrow, then a long press that must pause only once.
    Preset = 24'h000105;
    apply_stimulus(1'b0, 1'b1, 3);
    check_output("load_105", 24'h000105, 1'b0);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(20);
    check_output("tick5", 24'h000100, 1'b0);
    wait_clocks(4);
    check_output("sec_borrow", 24'h000099, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8);
    wait_clocks(20);
    check_output("held_pause", 24'h000099, 1'b0);

    // Pause after 9 run clocks, resume; expiry after 31 more run clocks.
    Preset = 24'h000010;
    apply_stimulus(1'b0, 1'b1, 3);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(7);
    apply_stimulus(1'b1, 1'b0, 3);
    check_output("paused", 24'h000008, 1'b0);
    wait_clocks(50);
    check_output("still_paused", 24'h000008, 1'b0);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(30);
    check_output("resume_30", 24'h000001, 1'b0);
    wait_clocks(1);
    check_output("resume_31", 24'h000000, 1'b1);

    // Expiry and the DONE guards.
    Preset = 24'h000002;
    apply_stimulus(1'b0, 1'b1, 3);
    check_output("load_002", 24'h000002, 1'b0);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(7);
    check_output("expiry_7", 24'h000001, 1'b0);
    wait_clocks(1);
    check_output("expiry_8", 24'h000000, 1'b1);
    wait_clocks(10);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(10);
    check_output("done_start_ignored", 24'h000000, 1'b1);
    Preset = 24'h000003;
    apply_stimulus(1'b0, 1'b1, 3);
    check_output("done_reload", 24'h000003, 1'b0);

    // Load during RUN is ignored.
    apply_stimulus(1'b1, 1'b0, 3);
    Preset = 24'h000050;
    apply_stimulus(1'b0, 1'b1, 3);
    wait_clocks(1);
    check_output("run_load_ignored", 24'h000002, 1'b0);
    wait_clocks(8);
    check_output("run_load_done", 24'h000000, 1'b1);

    // Start with a zero count stays idle.
    Preset = 24'h000000;
    apply_stimulus(1'b0, 1'b1, 3);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(20);
    check_output("zero_start", 24'h000000, 1'b0);

    // Simultaneous start and load while paused: the load wins.
    Preset = 24'h000020;
    apply_stimulus(1'b0, 1'b1, 3);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(2);
    apply_stimulus(1'b1, 1'b0, 3);
    check_output("pause_19", 24'h000019, 1'b0);
    Preset = 24'h000045;
    apply_stimulus(1'b1, 1'b1, 3);
    wait_clocks(20);
    check_output("both_load_wins", 24'h000045, 1'b0);

    // Preset saturation and a minutes borrow.
    Preset = 24'h7A6B0C;
    apply_stimulus(1'b0, 1'b1, 3);
    check_output("saturate", 24'h595909, 1'b0);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(4);
    check_output("sat_tick", 24'h595908, 1'b0);
    apply_stimulus(1'b1, 1'b0, 3);
    Preset = 24'h010000;
    apply_stimulus(1'b0, 1'b1, 3);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(4);
    check_output("min_borrow", 24'h005999, 1'b0);

    // Reset while running, then starts are ignored until a load.
    wait_clocks(5);
    Rst = 1'b0;
    wait_clocks(1);
    Rst = 1'b1;
    check_output("mid_run_reset", 24'h000000, 1'b0);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(10);
    check_output("post_reset_start", 24'h000000, 1'b0);
    Preset = 24'h000005;
    apply_stimulus(1'b0, 1'b1, 3);
    check_output("post_reset_load", 24'h000005, 1'b0);
    apply_stimulus(1'b1, 1'b0, 3);
    wait_clocks(20);
    check_output("post_reset_done", 24'h000000, 1'b1);

    wait_clocks(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
